// File: rtl/sys_rst_pkg.sv
// Shared definitions for the system reset sequencer: state encoding and counter sizing.
package sys_rst_pkg;

    localparam logic [1:0] ST_MRST = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    typedef enum logic [1:0] {
        S_MRST = ST_MRST,
        S_WAIT = ST_WAIT,
        S_REL  = ST_REL,
        S_RUN  = ST_RUN
    } state_t;

    // Bits needed for the shared counter, which counts up to (largest interval - 1).
    function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                              input int unsigned timeout,
                                              input int unsigned rel_cycles);
        int unsigned m;
        int unsigned w;
        m = rst_cycles;
        if (timeout > m)    m = timeout;
        if (rel_cycles > m) m = rel_cycles;
        w = 1;
        while ((32'd1 << w) < m) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for single-bit CDC, with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sys_rst_seq.sv
// Reset sequencer: pulses the MMCM reset, qualifies lock, then releases staged resets.
module sys_rst_seq
    import sys_rst_pkg::*;
#(
    parameter int unsigned MMCM_RST_CYCLES = 16,
    parameter int unsigned LOCK_STABLE     = 1024,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned STAGE_GAP       = 64,
    parameter int unsigned NUM_STAGES      = 2,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  locked_i,
    output logic                  mmcm_rst_o,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  ready_o,
    output logic [CNT_W-1:0]      lock_loss_cnt_o,
    output logic [CNT_W-1:0]      retry_cnt_o
);

    localparam int unsigned CW = cnt_width(MMCM_RST_CYCLES, LOCK_TIMEOUT, NUM_STAGES * STAGE_GAP);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   stable;
    logic            locked_s;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (locked_i),
        .q   (locked_s)
    );

    // cnt is shared: MRST pulse width, WAIT timeout, REL stage gaps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_MRST;
            cnt             <= '0;
            stable          <= '0;
            mmcm_rst_o      <= 1'b1;
            rst_o           <= '1;
            ready_o         <= 1'b0;
            lock_loss_cnt_o <= '0;
            retry_cnt_o     <= '0;
        end else begin
            case (state)
                S_MRST: begin
                    mmcm_rst_o <= 1'b1;
                    rst_o      <= '1;
                    ready_o    <= 1'b0;
                    if (cnt == CW'(MMCM_RST_CYCLES - 1)) begin
                        state      <= S_WAIT;
                        cnt        <= '0;
                        stable     <= '0;
                        mmcm_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    cnt    <= cnt + CW'(1);
                    stable <= locked_s ? stable + CW'(1) : '0;
                    // Stable lock takes priority over a coincident timeout.
                    if (locked_s && (stable == CW'(LOCK_STABLE - 1))) begin
                        state <= S_REL;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state      <= S_MRST;
                        cnt        <= '0;
                        mmcm_rst_o <= 1'b1;
                        if (retry_cnt_o != {CNT_W{1'b1}})
                            retry_cnt_o <= retry_cnt_o + CNT_W'(1);
                    end
                end
                S_REL, S_RUN: begin
                    if (!locked_s) begin
                        state      <= S_MRST;
                        cnt        <= '0;
                        mmcm_rst_o <= 1'b1;
                        rst_o      <= '1;
                        ready_o    <= 1'b0;
                        if (lock_loss_cnt_o != {CNT_W{1'b1}})
                            lock_loss_cnt_o <= lock_loss_cnt_o + CNT_W'(1);
                    end else if (state == S_REL) begin
                        cnt <= cnt + CW'(1);
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (cnt == CW'((k + 1) * STAGE_GAP - 1))
                                rst_o[k] <= 1'b0;
                        end
                        if (cnt == CW'(NUM_STAGES * STAGE_GAP - 1)) begin
                            ready_o <= 1'b1;
                            state   <= S_RUN;
                        end
                    end
                end
                default: state <= S_MRST;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_rst_seq.sv
// Scoreboard bench for sys_rst_seq: expected output changes (cycle + value) are queued by
// the stimulus and matched by a monitor against every observed change of the outputs.
module tb_sys_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       locked_i;
    logic       mmcm_rst_o;
    logic [1:0] rst_o;
    logic       ready_o;
    logic [3:0] lock_loss_cnt_o;
    logic [3:0] retry_cnt_o;

    sys_rst_seq #(
        .MMCM_RST_CYCLES (4),
        .LOCK_STABLE     (8),
        .LOCK_TIMEOUT    (32),
        .STAGE_GAP       (3),
        .NUM_STAGES      (2),
        .CNT_W           (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .locked_i        (locked_i),
        .mmcm_rst_o      (mmcm_rst_o),
        .rst_o           (rst_o),
        .ready_o         (ready_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .retry_cnt_o     (retry_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // cyc = number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [11:0] vec;   // {mmcm, rst[1:0], ready, loss[3:0], retry[3:0]}
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic push(input int c, input logic m, input logic [1:0] r, input logic rd,
                        input logic [3:0] ls, input logic [3:0] rt);
        exp_t e;
        e.cyc = c;
        e.vec = {m, r, rd, ls, rt};
        q.push_back(e);
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk_i);
    endtask

    // Monitor: every change of the output vector must match the next queued expectation.
    initial begin : monitor
        logic [11:0] cur;
        logic [11:0] prev;
        logic        first;
        exp_t        e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            cur = {mmcm_rst_o, rst_o, ready_o, lock_loss_cnt_o, retry_cnt_o};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                vectors++;
                errors++;
                $display("FAIL missing_change cyc=%0d: no output change seen, required %h", e.cyc, e.vec);
            end
            if (first || cur != prev) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d: outputs became %h, none required", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.vec != cur) begin
                        errors++;
                        $display("FAIL output_change: got %h at cyc %0d, required %h at cyc %0d",
                                 cur, cyc, e.vec, e.cyc);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    initial begin : stimulus
        rst_i    = 1'b1;
        locked_i = 1'b0;

        // Nominal bring-up: rst_i low after edge 3, lock rises after edge 8.
        push(1,  1'b1, 2'b11, 1'b0, 4'd0, 4'd0);     // reset values
        push(7,  1'b0, 2'b11, 1'b0, 4'd0, 4'd0);     // 4-cycle MMCM pulse ends
        push(21, 1'b0, 2'b10, 1'b0, 4'd0, 4'd0);     // 8 + 13
        push(24, 1'b0, 2'b00, 1'b1, 4'd0, 4'd0);     // + STAGE_GAP
        at_edge(3);  rst_i = 1'b0;
        at_edge(8);  locked_i = 1'b1;

        // Lock loss in RUN: 2-cycle drop after edge 30, lock already back for re-sequence.
        push(33, 1'b1, 2'b11, 1'b0, 4'd1, 4'd0);
        push(37, 1'b0, 2'b11, 1'b0, 4'd1, 4'd0);
        push(48, 1'b0, 2'b10, 1'b0, 4'd1, 4'd0);
        push(51, 1'b0, 2'b00, 1'b1, 4'd1, 4'd0);
        at_edge(30); locked_i = 1'b0;
        at_edge(32); locked_i = 1'b1;

        // Second loss, then glitchy lock in WAIT (5 high, 2 low, high from edge 71).
        push(58, 1'b1, 2'b11, 1'b0, 4'd2, 4'd0);
        push(62, 1'b0, 2'b11, 1'b0, 4'd2, 4'd0);
        push(84, 1'b0, 2'b10, 1'b0, 4'd2, 4'd0);     // 71 + 13
        // Loss mid-REL lands on the cycle stage 1 would release: loss wins.
        push(87, 1'b1, 2'b11, 1'b0, 4'd3, 4'd0);
        push(91, 1'b0, 2'b11, 1'b0, 4'd3, 4'd0);
        push(103, 1'b0, 2'b10, 1'b0, 4'd3, 4'd0);    // 90 + 13
        push(106, 1'b0, 2'b00, 1'b1, 4'd3, 4'd0);
        at_edge(55); locked_i = 1'b0;
        at_edge(64); locked_i = 1'b1;
        at_edge(69); locked_i = 1'b0;
        at_edge(71); locked_i = 1'b1;
        at_edge(84); locked_i = 1'b0;
        at_edge(90); locked_i = 1'b1;

        // rst_i during RUN with loss count 3: counters clear, fresh MMCM pulse.
        push(111, 1'b1, 2'b11, 1'b0, 4'd0, 4'd0);
        push(116, 1'b0, 2'b11, 1'b0, 4'd0, 4'd0);
        push(127, 1'b0, 2'b10, 1'b0, 4'd0, 4'd0);
        push(130, 1'b0, 2'b00, 1'b1, 4'd0, 4'd0);
        at_edge(110); rst_i = 1'b1;
        at_edge(112); rst_i = 1'b0;

        // Timeouts with lock held low: rise every 36 cycles, retry saturates at 15.
        push(136, 1'b1, 2'b11, 1'b0, 4'd0, 4'd0);
        push(140, 1'b0, 2'b11, 1'b0, 4'd0, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            push(136 + 36 * k, 1'b1, 2'b11, 1'b0, 4'd0, (k > 15) ? 4'd15 : 4'(k));
            push(140 + 36 * k, 1'b0, 2'b11, 1'b0, 4'd0, (k > 15) ? 4'd15 : 4'(k));
        end
        at_edge(135); rst_i = 1'b1; locked_i = 1'b0;
        at_edge(136); rst_i = 1'b0;

        at_edge(872);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            errors++;
            $display("FAIL leftover_change: required %h at cyc %0d, never seen", e.vec, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
